// File: rtl/div_iter_if.sv
// Operand/result bundle between the execute-stage datapath and the iterative divider.
// The datapath is the master; the divider is the slave.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_div;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_div;

    modport master (
        output a, b, signed_div, start, annul,
        input  result_o, ready_o, stall_div
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result_o, ready_o, stall_div
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls E for the whole operation
// and presents {remainder, quotient} for HI/LO with a one-cycle ready pulse.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

    divState_t        state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             signQ;
    logic             signR;
    logic             zeroDiv;

    logic             accept;
    logic             lastStep;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;
    logic [WIDTH-1:0] fixRem;
    logic [WIDTH-1:0] fixQuo;

    assign accept        = (state == IDLE) && bus.start && !bus.annul;
    assign lastStep      = (count == CW'(WIDTH - 1));
    assign bus.stall_div = accept || (state == BUSY);

    // Magnitudes: the most negative value maps onto itself, which is exactly
    // its unsigned magnitude, so overflow falls out of the algorithm.
    assign magA = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign magB = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One restoring step. The shifted partial remainder needs an extra bit since
    // it can reach 2*divisor-1. With a zero divisor the remainder ends up as |a|,
    // so the sign fix restores the original dividend; only the quotient is forced.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        nextRem = shifted[WIDTH-1:0];
        nextQuo = {quo[WIDTH-2:0], 1'b0};
        if (fits) begin
            nextRem = WIDTH'(shifted - {1'b0, divisor});
            nextQuo = {quo[WIDTH-2:0], 1'b1};
        end
        fixRem = signR ? -nextRem : nextRem;
        fixQuo = zeroDiv ? {WIDTH{1'b1}} : (signQ ? -nextQuo : nextQuo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            signQ        <= 1'b0;
            signR        <= 1'b0;
            zeroDiv      <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ready_o <= 1'b0;
                    if (accept) begin
                        rem     <= '0;
                        quo     <= magA;
                        divisor <= magB;
                        signQ   <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        signR   <= bus.signed_div & bus.a[WIDTH-1];
                        zeroDiv <= (bus.b == '0);
                        count   <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.annul) begin
                        state <= IDLE;
                    end else begin
                        rem   <= nextRem;
                        quo   <= nextQuo;
                        count <= count + CW'(1);
                        if (lastStep) begin
                            bus.result_o <= {fixRem, fixQuo};
                            bus.ready_o  <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.ready_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.ready_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, stall window, signed/unsigned results,
// divide-by-zero, annul, reset and back-to-back operation.
module tb_div_iter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cycleCount;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full divide from a start pulse in IDLE to the IDLE cycle after DONE.
    // Operands are scrambled after cycle 0 so the result proves they were latched.
    task automatic applyStimulus(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                                 input logic sgn, input logic [63:0] expResult);
        int   lat;
        logic stallOk;
        bus.a          = opA;
        bus.b          = opB;
        bus.signed_div = sgn;
        bus.start      = 1'b1;
        bus.annul      = 1'b0;
        #1;
        checkOutput({tag, "_stallStart"}, 64'(bus.stall_div), 64'd1);
        tick();
        bus.start = 1'b0;
        bus.a     = ~opA;
        bus.b     = opB ^ 32'h5A5A_0001;
        lat       = 1;
        stallOk   = 1'b1;
        while (!bus.ready_o && lat < 40) begin
            if (!bus.stall_div) stallOk = 1'b0;
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
        checkOutput({tag, "_stallBusy"}, 64'(stallOk), 64'd1);
        checkOutput({tag, "_stallDone"}, 64'(bus.stall_div), 64'd0);
        checkOutput({tag, "_result"}, bus.result_o, expResult);
        tick();
        checkOutput({tag, "_readyDrop"}, 64'(bus.ready_o), 64'd0);
        checkOutput({tag, "_resultHold"}, bus.result_o, expResult);
    endtask

    initial begin
        int readyCount;
        int firstReady;
        int lat;
        checks         = 0;
        failures       = 0;
        cycleCount     = 0;
        rst            = 1'b1;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_div = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("resetResult", bus.result_o, 64'd0);
        checkOutput("resetReady", 64'(bus.ready_o), 64'd0);
        checkOutput("resetStall", 64'(bus.stall_div), 64'd0);
        tick();

        applyStimulus("udiv100by7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E});
        applyStimulus("sdivM7by2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        applyStimulus("sdiv7byM2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        applyStimulus("sdivOvf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
        applyStimulus("udivBig", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, {32'h7FFF_FFFE, 32'h0000_0001});
        applyStimulus("udivZero", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
        applyStimulus("sdivZero", 32'h1234_5678, 32'h0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF});

        // Annul lands in BUSY cycle 10; nothing may come out afterwards.
        bus.a          = 32'd100;
        bus.b          = 32'd7;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        checkOutput("annulIdleStall", 64'(bus.stall_div), 64'd0);
        readyCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o) readyCount++;
            tick();
        end
        checkOutput("annulNoReady", 64'(readyCount), 64'd0);
        checkOutput("annulResultHold", bus.result_o, {32'h1234_5678, 32'hFFFF_FFFF});
        applyStimulus("restart9by3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3});

        // Reset in BUSY cycle 20 clears everything on the next cycle.
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midResetResult", bus.result_o, 64'd0);
        checkOutput("midResetReady", 64'(bus.ready_o), 64'd0);
        checkOutput("midResetStall", 64'(bus.stall_div), 64'd0);
        tick();
        checkOutput("midResetStaysIdle", 64'(bus.stall_div), 64'd0);

        // Back-to-back with start held through DONE: ready pulses land in
        // cycles 33 and 67 of the sequence, i.e. 34 edges apart.
        bus.a     = 32'd10;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        lat = 1;
        while (!bus.ready_o && lat < 40) begin
            tick();
            lat++;
        end
        firstReady = cycleCount;
        checkOutput("b2bFirstLatency", 64'(lat), 64'd33);
        checkOutput("b2bFirstResult", bus.result_o, {32'h1, 32'h3});
        checkOutput("b2bDoneStall", 64'(bus.stall_div), 64'd0);
        bus.a = 32'd20;
        bus.b = 32'd6;
        tick();
        checkOutput("b2bIdleStall", 64'(bus.stall_div), 64'd1);
        tick();
        lat = 0;
        while (!bus.ready_o && lat < 40) begin
            tick();
            lat++;
        end
        bus.start = 1'b0;
        checkOutput("b2bGap", 64'(cycleCount - firstReady), 64'd34);
        checkOutput("b2bSecondResult", bus.result_o, {32'h2, 32'h3});
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
